// File: rtl/crc_frame_ctrl.sv
// Sequencer for a shared external CRC engine: seeds the engine, streams a fixed
// number of bytes into it, then captures the XORed result and flags completion.
//
// state | meaning
// IDLE  | waiting for cmd_start; zero-length commands report err
// INIT  | one-cycle engine seed pulse
// RUN   | accepting bytes until the latched count is exhausted
// WAIT  | one cycle for the registered engine result to settle
// DONE  | one-cycle completion pulse, crc_out valid
module crc_frame_ctrl #(
   parameter int                DATA_W  = 8,
   parameter int                CRC_W   = 16,
   parameter int                LEN_W   = 8,
   parameter logic [CRC_W-1:0]  XOR_OUT = 16'h0000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_start,
   input  logic [LEN_W-1:0]   cmd_len,
   input  logic               abort,
   input  logic               in_valid,
   input  logic [DATA_W-1:0]  in_data,
   output logic               in_ready,
   output logic               eng_init,
   output logic               eng_en,
   output logic [DATA_W-1:0]  eng_data,
   input  logic [CRC_W-1:0]   eng_crc,
   output logic               busy,
   output logic [CRC_W-1:0]   crc_out,
   output logic               done,
   output logic               done_tgl,
   output logic               err
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      INIT = 3'd1,
      RUN  = 3'd2,
      WAIT = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t            state, state_nxt;
   logic [LEN_W-1:0]  remaining, remaining_nxt;
   logic              err_nxt;
   logic              accept;

   assign in_ready = (state == RUN);
   assign accept   = in_valid & in_ready;
   assign eng_en   = accept;
   assign eng_data = in_ready ? in_data : '0;
   assign eng_init = (state == INIT);
   assign busy     = (state != IDLE);
   assign done     = (state == DONE);

   always_comb begin
      state_nxt     = state;
      remaining_nxt = remaining;
      err_nxt       = 1'b0;
      case (state)
         IDLE: begin
            if (cmd_start) begin
               if (cmd_len != '0) begin
                  remaining_nxt = cmd_len;
                  state_nxt     = INIT;
               end else begin
                  err_nxt = 1'b1;
               end
            end
         end
         INIT: begin
            state_nxt = RUN;
         end
         RUN: begin
            if (accept) begin
               remaining_nxt = remaining - LEN_W'(1);
               if (remaining == LEN_W'(1)) state_nxt = WAIT;
            end
         end
         WAIT: begin
            state_nxt = DONE;
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      // abort discards the frame; DONE is already committed and ignores it
      if (abort && (state == INIT || state == RUN || state == WAIT)) begin
         state_nxt     = IDLE;
         remaining_nxt = '0;
         err_nxt       = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         remaining <= '0;
         err       <= 1'b0;
         crc_out   <= '0;
         done_tgl  <= 1'b0;
      end else begin
         state     <= state_nxt;
         remaining <= remaining_nxt;
         err       <= err_nxt;
         if (state == WAIT && !abort) begin
            crc_out  <= eng_crc ^ XOR_OUT;
            done_tgl <= ~done_tgl;
         end
      end
   end

endmodule
